// File: rtl/wr_pulse_gen_fixed_delay.sv
// Fixed-delay trigger regenerator: re-emits RX trigger timestamps as pulses
// at a constant latency measured against local WR time.
//
// Ports:
//   clk_ref_i        125 MHz WR reference clock
//   rst_i            synchronous active-high reset
//   ts_valid_i       one-cycle strobe, trigger timestamp present
//   ts_tai_i         trigger TAI seconds
//   ts_cycles_i      trigger ref-cycle count
//   tm_time_valid_i  local WR time valid
//   tm_tai_i         local TAI seconds
//   tm_cycles_i      local ref-cycle count
//   pulse_o          regenerated trigger pulse
//   busy_o           triggers pending or FSM not idle
//   cnt_late_o       triggers dropped because their target had passed
//   cnt_ovf_o        triggers dropped on full queue or invalid time
module wr_pulse_gen_fixed_delay #(
    parameter int unsigned g_delay_cycles = 2500,
    parameter int unsigned g_pulse_width  = 125,
    parameter int unsigned g_fifo_depth   = 8,
    parameter int unsigned g_clk_freq     = 125000000
) (
    input  logic        clk_ref_i,
    input  logic        rst_i,
    input  logic        ts_valid_i,
    input  logic [39:0] ts_tai_i,
    input  logic [27:0] ts_cycles_i,
    input  logic        tm_time_valid_i,
    input  logic [39:0] tm_tai_i,
    input  logic [27:0] tm_cycles_i,
    output logic        pulse_o,
    output logic        busy_o,
    output logic [15:0] cnt_late_o,
    output logic [15:0] cnt_ovf_o
);

    localparam int unsigned AW =
        (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;
    localparam int unsigned PW =
        (g_pulse_width > 1) ? $clog2(g_pulse_width) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, PULSE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Delay stage
    logic        d_valid;
    logic [39:0] d_tai;
    logic [27:0] d_cyc;
    logic [28:0] sum;

    assign sum = {1'b0, ts_cycles_i} + 29'(g_delay_cycles);

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            d_valid <= 1'b0;
            d_tai   <= '0;
            d_cyc   <= '0;
        end else begin
            d_valid <= ts_valid_i;
            if (ts_valid_i) begin
                if (sum >= 29'(g_clk_freq)) begin
                    d_cyc <= 28'(sum - 29'(g_clk_freq));
                    d_tai <= ts_tai_i + 40'd1;
                end else begin
                    d_cyc <= sum[27:0];
                    d_tai <= ts_tai_i;
                end
            end
        end
    end

    // Target queue
    state_t        state;
    logic [67:0]   mem [g_fifo_depth];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   fcnt;
    logic [AW+1:0] pending;
    logic          full;
    logic          wr_en;
    logic          pop;
    logic [67:0]   head;
    logic [67:0]   now;
    logic [67:0]   target;
    logic [PW-1:0] pw_cnt;

    // The armed entry still counts as pending, so capacity covers it.
    assign pending = {1'b0, fcnt} + (AW + 2)'(state == ARMED);
    assign full    = pending >= (AW + 2)'(g_fifo_depth);
    assign wr_en   = d_valid && tm_time_valid_i && !full;
    assign pop     = (state == LOAD) && tm_time_valid_i;
    assign head    = mem[rp];
    assign now     = {tm_tai_i, tm_cycles_i};

    always_ff @(posedge clk_ref_i) begin
        if (wr_en) mem[wp] <= {d_tai, d_cyc};
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            fcnt       <= '0;
            target     <= '0;
            pw_cnt     <= '0;
            pulse_o    <= 1'b0;
            busy_o     <= 1'b0;
            cnt_late_o <= '0;
            cnt_ovf_o  <= '0;
        end else begin
            busy_o <= (fcnt != '0) || (state != IDLE);
            if (d_valid && !wr_en) cnt_ovf_o <= sat_inc(cnt_ovf_o);

            if (!tm_time_valid_i) begin
                // Time lost: pending targets are meaningless, drop silently.
                wp      <= '0;
                rp      <= '0;
                fcnt    <= '0;
                state   <= IDLE;
                pulse_o <= 1'b0;
            end else begin
                if (wr_en) wp <= wp + 1'b1;
                if (pop)   rp <= rp + 1'b1;
                unique case ({wr_en, pop})
                    2'b10:   fcnt <= fcnt + 1'b1;
                    2'b01:   fcnt <= fcnt - 1'b1;
                    default: fcnt <= fcnt;
                endcase

                unique case (state)
                    IDLE: begin
                        if (fcnt != '0) state <= LOAD;
                    end
                    LOAD: begin
                        target <= head;
                        if (head <= now) begin
                            cnt_late_o <= sat_inc(cnt_late_o);
                            state      <= IDLE;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (now == target) begin
                            state   <= PULSE;
                            pulse_o <= 1'b1;
                            pw_cnt  <= PW'(g_pulse_width - 1);
                        end else if (now > target) begin
                            // Time jumped over the target.
                            cnt_late_o <= sat_inc(cnt_late_o);
                            state      <= IDLE;
                        end
                    end
                    PULSE: begin
                        if (pw_cnt == '0) begin
                            pulse_o <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            pw_cnt <= pw_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wr_pulse_gen_fixed_delay.sv
// Testbench for wr_pulse_gen_fixed_delay.
// Expected pulse times are queued at stimulus and matched on each rising edge.
module tb_wr_pulse_gen_fixed_delay;

    localparam int unsigned CLK_FREQ = 125000000;
    localparam int unsigned DELAY    = 2500;
    localparam int unsigned WIDTH    = 125;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ts_valid = 1'b0;
    logic [39:0] ts_tai = '0;
    logic [27:0] ts_cyc = '0;
    logic        tm_valid = 1'b1;
    logic [39:0] tm_tai = '0;
    logic [27:0] tm_cyc = '0;
    logic        pulse;
    logic        busy;
    logic [15:0] cnt_late;
    logic [15:0] cnt_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int width   = 0;
    logic prev_p = 1'b0;
    logic [67:0] exp_q [$];
    logic [15:0] exp_late = 0;
    logic [15:0] exp_ovf  = 0;

    always #4 clk = ~clk;

    wr_pulse_gen_fixed_delay dut (
        .clk_ref_i      (clk),
        .rst_i          (rst),
        .ts_valid_i     (ts_valid),
        .ts_tai_i       (ts_tai),
        .ts_cycles_i    (ts_cyc),
        .tm_time_valid_i(tm_valid),
        .tm_tai_i       (tm_tai),
        .tm_cycles_i    (tm_cyc),
        .pulse_o        (pulse),
        .busy_o         (busy),
        .cnt_late_o     (cnt_late),
        .cnt_ovf_o      (cnt_ovf)
    );

    task automatic chk(input string tag, input logic [67:0] got,
                       input logic [67:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then advance
    // local time. The sampled time is the one the DUT matched on.
    task automatic step();
        logic [67:0] e;
        @(posedge clk);
        #1;
        if (pulse && !prev_p) begin
            width = 0;
            if (exp_q.size() == 0) begin
                chk("extra_pulse", 68'd1, 68'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_at", {tm_tai, tm_cyc}, e);
            end
        end
        if (pulse) width++;
        if (!pulse && prev_p) chk("pulse_w", 68'(width), 68'(WIDTH));
        prev_p = pulse;
        if (tm_cyc == 28'(CLK_FREQ - 1)) begin
            tm_cyc = '0;
            tm_tai = tm_tai + 40'd1;
        end else begin
            tm_cyc = tm_cyc + 28'd1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input logic [39:0] t, input logic [27:0] c);
        tm_tai = t;
        tm_cyc = c;
    endtask

    task automatic strobe(input logic [39:0] t, input logic [27:0] c);
        ts_valid = 1'b1;
        ts_tai   = t;
        ts_cyc   = c;
        step();
        ts_valid = 1'b0;
    endtask

    // Expected target for a trigger that fits in the same second.
    function automatic logic [67:0] tgt(input logic [39:0] t,
                                        input logic [27:0] c);
        return {t, c + 28'(DELAY)};
    endfunction

    // Wait for all expected pulses; optionally skip idle time forward to
    // just before the next target to keep the run short.
    task automatic wait_pulses(input bit jump, input int budget);
        int n = 0;
        logic [67:0] nx;
        while ((exp_q.size() > 0 || pulse) && n < budget) begin
            if (jump && !pulse && exp_q.size() > 0) begin
                nx = exp_q[0];
                if (nx[27:0] >= 28'd20 && {tm_tai, tm_cyc} + 68'd20 < nx)
                    set_time(nx[67:28], nx[27:0] - 28'd20);
            end
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 68'd1, 68'd0);
        run(5);
    endtask

    initial begin
        // Reset
        set_time(40'd100, 28'd1000);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        step();
        chk("rst_pulse", 68'(pulse), 68'd0);
        chk("rst_busy", 68'(busy), 68'd0);
        chk("rst_late", 68'(cnt_late), 68'd0);
        chk("rst_ovf", 68'(cnt_ovf), 68'd0);

        // 1: basic fixed delay
        set_time(40'd100, 28'd1000);
        exp_q.push_back({40'd100, 28'd3500});
        strobe(40'd100, 28'd1000);
        wait_pulses(1'b0, 10000);
        chk("t1_late", 68'(cnt_late), 68'(exp_late));
        chk("t1_ovf", 68'(cnt_ovf), 68'(exp_ovf));
        chk("t1_busy", 68'(busy), 68'd0);

        // 2: seconds wrap
        set_time(40'd7, 28'd124999000);
        exp_q.push_back({40'd8, 28'd1500});
        strobe(40'd7, 28'd124999000);
        wait_pulses(1'b1, 5000);

        // 3: late trigger
        set_time(40'd60, 28'd0);
        strobe(40'd50, 28'd0);
        run(10);
        exp_late++;
        chk("t3_late", 68'(cnt_late), 68'(exp_late));

        // 4: overflow, 10 back-to-back strobes 1 ms apart
        set_time(40'd200, 28'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(tgt(40'd200, 28'(i * 125000)));
            strobe(40'd200, 28'(i * 125000));
        end
        wait_pulses(1'b1, 8000);
        exp_ovf += 2;
        chk("t4_ovf", 68'(cnt_ovf), 68'(exp_ovf));
        chk("t4_late", 68'(cnt_late), 68'(exp_late));

        // 5: second trigger lands inside the first pulse
        set_time(40'd300, 28'd0);
        exp_q.push_back(tgt(40'd300, 28'd0));
        strobe(40'd300, 28'd0);
        run(61);
        strobe(40'd300, 28'd62);
        wait_pulses(1'b1, 5000);
        exp_late++;
        chk("t5_late", 68'(cnt_late), 68'(exp_late));

        // 6a: time loss while armed with 3 queued
        set_time(40'd400, 28'd0);
        for (int i = 0; i < 4; i++) strobe(40'd400, 28'(i * 1000));
        run(10);
        chk("t6a_busy_pre", 68'(busy), 68'd1);
        tm_valid = 1'b0;
        step();
        tm_valid = 1'b1;
        run(3);
        chk("t6a_busy", 68'(busy), 68'd0);
        chk("t6a_pulse", 68'(pulse), 68'd0);
        run(6000);
        chk("t6a_late", 68'(cnt_late), 68'(exp_late));
        chk("t6a_ovf", 68'(cnt_ovf), 68'(exp_ovf));

        // 6b: reset while armed with 3 queued
        set_time(40'd500, 28'd0);
        for (int i = 0; i < 4; i++) strobe(40'd500, 28'(i * 1000));
        run(10);
        chk("t6b_busy_pre", 68'(busy), 68'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3);
        chk("t6b_busy", 68'(busy), 68'd0);
        chk("t6b_late", 68'(cnt_late), 68'd0);
        chk("t6b_ovf", 68'(cnt_ovf), 68'd0);
        run(6000);
        chk("t6b_pulse", 68'(pulse), 68'd0);
        chk("t6b_busy_end", 68'(busy), 68'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_pulse_gen_fixed_delay.md
Name: wr_pulse_gen_fixed_delay

Overview:
- Receive-side trigger regenerator. It consumes trigger timestamps delivered by the RX streamer and re-emits each trigger as a pulse at a fixed latency, for example 20 us after the original input edge.
- Each timestamp is offset by the configured delay and queued in a small FIFO. The head entry is compared against local WR time, and pulse_o is driven when it matches.
- Sits between the RX streamer output and the DIO output buffer.

Parameters:
- g_delay_cycles, 2500, fixed latency in 8 ns ref cycles (2500 = 20 us); valid range 0 to 124999999.
- g_pulse_width, 125, output pulse width in ref cycles (125 = 1 us); minimum 1.
- g_fifo_depth, 8, number of pending triggers held; must be a power of 2.
- g_clk_freq, 125000000, ref cycles per second; wrap point of the cycles field.

Ports:
- clk_ref_i  in  1  125 MHz WR reference clock.
- rst_i  in  1  synchronous reset, active-high.
- ts_valid_i  in  1  one-cycle strobe: timestamp present. No backpressure.
- ts_tai_i  in  40  trigger TAI seconds.
- ts_cycles_i  in  28  trigger ref-cycle count, 0 to g_clk_freq-1.
- tm_time_valid_i  in  1  local WR time valid.
- tm_tai_i  in  40  local TAI seconds.
- tm_cycles_i  in  28  local ref-cycle count.
- pulse_o  out  1  regenerated trigger pulse.
- busy_o  out  1  FIFO not empty, or pulse active.
- cnt_late_o  out  16  triggers dropped because their target time had already passed; saturating.
- cnt_ovf_o  out  16  triggers dropped because the FIFO was full or time was invalid; saturating.

Behaviour:
- Reset: pulse_o=0, busy_o=0, cnt_late_o=0, cnt_ovf_o=0, FIFO emptied, FSM in IDLE. Reset applied mid-pulse terminates the pulse in the next cycle.
- Delay stage (1 cycle, registered):
  - sum = ts_cycles_i + g_delay_cycles, computed at 29 bits.
  - If sum >= g_clk_freq: target cycles = sum - g_clk_freq, target TAI = ts_tai_i + 1.
  - Otherwise: target = (ts_tai_i, sum).
  - TAI arithmetic wraps modulo 2^40.
- FIFO write: the cycle after a strobe, the target is written into the FIFO.
  - If the FIFO is full at that moment, the entry is discarded and cnt_ovf_o increments.
  - If tm_time_valid_i=0, the entry is discarded and cnt_ovf_o increments.
  - Back-to-back strobes on consecutive cycles must all be accepted.
  - Simultaneous write and read of the FIFO are both allowed in the same cycle.
- FSM states: IDLE, LOAD, ARMED, PULSE.
  - IDLE: when the FIFO is non-empty, go to LOAD.
  - LOAD (1 cycle): pop the head into the target register.
    - If target <= (tm_tai_i, tm_cycles_i) in lexicographic order: increment cnt_late_o and return to IDLE.
    - Otherwise: go to ARMED.
  - ARMED:
    - When (tm_tai_i, tm_cycles_i) == target: go to PULSE and assert pulse_o, registered. pulse_o is high starting the cycle after local time equals target.
    - If local time exceeds target without an exact match (time jump): increment cnt_late_o and return to IDLE.
  - PULSE: hold pulse_o=1 for exactly g_pulse_width cycles, then pulse_o=0 and go to IDLE.
    - Triggers arriving during PULSE are queued normally.
    - A queued target that falls inside the active pulse is found late at LOAD and dropped.
- Time loss: while tm_time_valid_i=0, the FIFO is flushed and the FSM forced to IDLE.
  - pulse_o is forced to 0 in the following cycle.
  - Flushed entries are not counted.
- Counters saturate at 0xFFFF and never wrap.
- busy_o is registered: 1 when the FIFO is non-empty or the state is not IDLE.

Test Plan:
1. Time valid, local time (100, 1000). Strobe ts=(100, 1000), defaults -> pulse_o high during the cycle after local time (100, 3500), exactly 125 cycles wide; both counters remain 0.
2. Wrap-around: ts=(7, 124999000), delay 2500 -> target (8, 1500); pulse_o rises the cycle after local time (8, 1500).
3. Late: ts=(50, 0) while local time is (60, 0) -> no pulse; cnt_late_o=1.
4. Overflow: 10 consecutive strobes with targets 1 ms apart, depth 8 -> 8 pulses emitted in order; cnt_ovf_o=2.
5. Overlap: two triggers 500 ns apart (62 cycles), width 125 -> a single 125-cycle pulse; cnt_late_o=1.
6. Disturbance: drop tm_time_valid_i for 1 cycle, or assert rst_i, during ARMED with 3 queued entries -> pulse_o stays 0, busy_o goes to 0, no further pulses.
   - After reset, counters read 0.
   - After time loss, counters are unchanged.
